// File: rtl/osc_freq_monitor_if.sv
// Status/control bundle between the oscillator frequency monitor and the fabric health logic.
// Signal names follow the block's published port list.
interface osc_freq_monitor_if #(
    parameter int CNT_W = 24
);
    logic             EN;
    logic             REF_TICK;
    logic             ERR_CLR;
    logic [CNT_W-1:0] COUNT_VALUE;
    logic             COUNT_VALID;
    logic             FREQ_OK;
    logic             FREQ_ERR;
    logic             REF_LOST;

    modport master (
        output EN, REF_TICK, ERR_CLR,
        input  COUNT_VALUE, COUNT_VALID, FREQ_OK, FREQ_ERR, REF_LOST
    );

    modport slave (
        input  EN, REF_TICK, ERR_CLR,
        output COUNT_VALUE, COUNT_VALID, FREQ_OK, FREQ_ERR, REF_LOST
    );
endinterface

// File: rtl/osc_freq_monitor.sv
// Measures CLK cycles between rising edges of an asynchronous reference tick and flags
// out-of-tolerance windows and reference loss.
module osc_freq_monitor #(
    parameter int CNT_W     = 24,
    parameter int EXP_COUNT = 160000,
    parameter int TOL       = 160,
    parameter int TIMEOUT   = 320000,
    parameter int GOOD_N    = 4
) (
    input  logic                CLK,
    input  logic                RESETN,
    osc_freq_monitor_if.slave   mon
);
    localparam int GR_W = $clog2(GOOD_N + 1);
    // Limits carry one extra bit so EXP_COUNT+TOL near the top of the range cannot wrap.
    localparam logic [CNT_W:0]   LO_C   = (CNT_W+1)'(EXP_COUNT - TOL);
    localparam logic [CNT_W:0]   HI_C   = (CNT_W+1)'(EXP_COUNT + TOL);
    localparam logic [CNT_W-1:0] TO_C   = CNT_W'(TIMEOUT);
    localparam logic [GR_W-1:0]  GN_C   = GR_W'(GOOD_N);
    localparam logic [GR_W-1:0]  GN_M1C = GR_W'(GOOD_N - 1);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [GR_W-1:0]  good_q;
    logic             sync1_q, sync2_q, hist_q;
    logic [CNT_W-1:0] cval_q;
    logic             cvld_q, ok_q, err_q, lost_q;

    logic ref_rise;
    logic in_range;

    assign ref_rise = sync2_q & ~hist_q;
    assign in_range = ({1'b0, cnt_q} >= LO_C) && ({1'b0, cnt_q} <= HI_C);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            good_q  <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
            cval_q  <= '0;
            cvld_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            sync1_q <= mon.REF_TICK;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            cvld_q  <= 1'b0;

            // Clear first so any set condition below in the same cycle overrides it.
            if (mon.ERR_CLR) begin
                err_q  <= 1'b0;
                lost_q <= 1'b0;
            end

            if (!mon.EN) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                good_q  <= '0;
                ok_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= ARM;
                        cnt_q   <= '0;
                    end
                    ARM: begin
                        if (ref_rise) begin
                            state_q <= MEASURE;
                            cnt_q   <= CNT_W'(1);
                        end else if (cnt_q == TO_C) begin
                            lost_q  <= 1'b1;
                            ok_q    <= 1'b0;
                            good_q  <= '0;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    MEASURE: begin
                        if (ref_rise) begin
                            cval_q <= cnt_q;
                            cvld_q <= 1'b1;
                            // Edge cycle is the first cycle of the next window.
                            cnt_q  <= CNT_W'(1);
                            if (in_range) begin
                                if (good_q < GN_C) good_q <= good_q + GR_W'(1);
                                if (good_q >= GN_M1C) ok_q <= 1'b1;
                            end else begin
                                good_q <= '0;
                                ok_q   <= 1'b0;
                                err_q  <= 1'b1;
                            end
                        end else if (cnt_q == TO_C) begin
                            state_q <= ARM;
                            lost_q  <= 1'b1;
                            ok_q    <= 1'b0;
                            good_q  <= '0;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign mon.COUNT_VALUE = cval_q;
    assign mon.COUNT_VALID = cvld_q;
    assign mon.FREQ_OK     = ok_q;
    assign mon.FREQ_ERR    = err_q;
    assign mon.REF_LOST    = lost_q;
endmodule
